// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift {rem,quo} left, try rem - divisor, keep it if non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_in < divisor, so the WIDTH+1 bit difference never wraps past its sign bit.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/busy/done handshake.
// Signed operation is built only when DIV32_SEQ_SIGNED_EN is defined; otherwise all ops are unsigned.
module div32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output div_state_e       fsm_state
);

    // Handshake: start is taken on any rising edge where busy=0 (including the done cycle);
    // done pulses for one cycle and quotient/remainder/div_by_zero are valid from that cycle on.

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH-1:0] quo_fixed, rem_fixed;
    logic             zero_div;
    logic             accept;

    assign accept = start && (state == IDLE);

`ifdef DIV32_SEQ_SIGNED_EN
    logic dividend_neg, divisor_neg, neg_q, neg_r;

    assign dividend_neg = signed_op & dividend[WIDTH-1];
    assign divisor_neg  = signed_op & divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg ? -divisor : divisor;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend_neg ^ divisor_neg;
            neg_r <= dividend_neg;
        end
    end

    assign quo_fixed = neg_q ? -quo : quo;
    assign rem_fixed = neg_r ? -rem : rem;
`else
    logic signed_op_unused;

    assign signed_op_unused = signed_op;
    assign dividend_mag     = dividend;
    assign divisor_mag      = divisor;
    assign quo_fixed        = quo;
    assign rem_fixed        = rem;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (divisor == '0) ? FIX : RUN;
            RUN:     if (count == LAST_ITER) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        fsm_state = state;
    end

    // On a zero divisor quo keeps the raw dividend so it can be returned as the remainder.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            count    <= '0;
            zero_div <= 1'b0;
        end else if (accept) begin
            rem      <= '0;
            quo      <= (divisor == '0) ? dividend : dividend_mag;
            dvs      <= divisor_mag;
            count    <= '0;
            zero_div <= (divisor == '0);
        end else if (state == RUN) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                quotient    <= zero_div ? '1 : quo_fixed;
                remainder   <= zero_div ? quo : rem_fixed;
                div_by_zero <= zero_div;
            end
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq; expected values are hand-computed for the build selected by DIV32_SEQ_SIGNED_EN.
module tb_div32_seq;
    import div_pkg::*;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    div_state_e  fsm_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    div32_seq #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .fsm_state   (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits (from #1 after E0) for done, checking busy stays high and the edge count from E0.
    task automatic wait_done(input string tag, input int exp_lat);
        int  cyc = 0;
        bit  busy_ok = 1'b1;
        while (!done && cyc < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        check_eq({tag, "_busy_run"}, busy_ok, 1);
        check_eq({tag, "_latency"}, cyc, exp_lat);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic check_results(input string tag, input logic exp_dz);
        logic [31:0] eq, er;
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        check_eq({tag, "_quotient"}, quotient, eq);
        check_eq({tag, "_remainder"}, remainder, er);
        check_eq({tag, "_dz"}, div_by_zero, exp_dz);
    endtask

    task automatic run_op(input string tag, input logic sop, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
        exp_q.push_back(eq);
        exp_q.push_back(er);
        dividend  = a;
        divisor   = b;
        signed_op = sop;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = 1'($urandom_range(0, 1));
        check_eq({tag, "_busy_e0"}, busy, 1);
        wait_done(tag, elat);
        check_results(tag, edz);
        @(posedge clock); #1;
        check_eq({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int saw_done;
        clear_n   = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_quotient", quotient, 0);
        check_eq("rst_remainder", remainder, 0);
        check_eq("rst_dz", div_by_zero, 0);
        check_eq("rst_state", fsm_state, IDLE);
        clear_n = 1'b1;
        @(posedge clock); #1;

        run_op("u_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_op("zero_div", 1'b0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1);
        run_op("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33);
        run_op("u_dead", 1'b0, 32'hDEADBEEF, 32'h1000, 32'h000DEADB, 32'h00000EEF, 1'b0, 33);
        run_op("u_small", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
        run_op("s_zero_div", 1'b1, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1);
`ifdef DIV32_SEQ_SIGNED_EN
        run_op("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
        run_op("s_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 33);
        run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33);
        run_op("s_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 33);
`else
        run_op("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0, 33);
        run_op("s_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'd0, 32'd100, 1'b0, 33);
        run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33);
        run_op("s_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFF9, 1'b0, 33);
`endif

        // Back-to-back: start stays high with the second op's operands throughout the first op.
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd2);
        dividend  = 32'd100;
        divisor   = 32'd7;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clock); #1;
        dividend  = 32'hDEADBEEF;
        divisor   = 32'h1000;
        wait_done("b2b_a", 33);
        check_results("b2b_a", 1'b0);
        exp_q.push_back(32'h000DEADB);
        exp_q.push_back(32'h00000EEF);
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("b2b_no_bubble", busy, 1);
        check_eq("b2b_done_drop", done, 0);
        wait_done("b2b_b", 33);
        check_results("b2b_b", 1'b0);
        @(posedge clock); #1;

        // Asynchronous abort at E0+10.
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        clear_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_quotient", quotient, 0);
        check_eq("abort_remainder", remainder, 0);
        check_eq("abort_state", fsm_state, IDLE);
        @(posedge clock); #2;
        clear_n  = 1'b1;
        saw_done = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) saw_done++;
        end
        check_eq("abort_no_done", saw_done, 0);
        check_eq("abort_dz", div_by_zero, 0);

        run_op("after_abort", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
